// File: rtl/shift_chain_pkg.sv
// Shared types and width helpers for the 74HC595 chain driver.
package shift_chain_pkg;

  // Serial phases of one frame transfer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_CLOCK = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_chain_driver_phase_timer.sv
// Phase timer: reloads to CLK_DIV-1 on each phase entry and flags the last
// cycle of the phase. Shared by SETUP, CLOCK and LATCH.
module shift_chain_driver_phase_timer
  import shift_chain_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic tc_o
);

  localparam int TW = cnt_w(CLK_DIV);
  localparam logic [TW-1:0] LOAD_VAL = TW'(CLK_DIV - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/shift_chain_driver.sv
// Serial driver for NUM_CHAINS parallel daisy-chained 74HC595 strings sharing
// SHCP/STCP. A frame is latched only after all bits are shifted; one request
// arriving mid-transfer is buffered (latest wins) and follows without a gap.
module shift_chain_driver
  import shift_chain_pkg::*;
#(
  parameter int NUM_ICS    = 2,
  parameter int NUM_CHAINS = 1,
  parameter int CLK_DIV    = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [NUM_CHAINS*NUM_ICS*8-1:0] data_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            sclk_o,
  output logic [NUM_CHAINS-1:0]           data_o,
  output logic                            latch_o
);

  localparam int NB = NUM_ICS * 8;
  localparam int FW = NUM_CHAINS * NB;
  localparam int CW = cnt_w(NB);
  localparam logic [CW-1:0] LAST_BIT = CW'(NB - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_q, bit_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic [FW-1:0]   pending_q, pending_d;
  logic            pend_vld_q, pend_vld_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sclk_q, sclk_d;
  logic            latch_q, latch_d;
  logic [NUM_CHAINS-1:0] data_q, data_d;

  logic            phase_tc;
  logic            phase_load;
  logic [CW-1:0]   sel;
  logic [NB-1:0]   chain_w [NUM_CHAINS];
  logic [NUM_CHAINS-1:0] setup_bits;

  // A state change always starts a fresh phase of CLK_DIV cycles.
  assign phase_load = (state_d != state_q);

  shift_chain_driver_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (phase_load),
    .tc_o   (phase_tc)
  );

  // Bit presented on entering SETUP, taken from the next-cycle shadow/counter
  // so the pin register updates on the same edge as the state.
  assign sel = (MSB_FIRST != 0) ? bit_d : (LAST_BIT - bit_d);

  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_chain
    assign chain_w[g]    = shadow_d[g*NB +: NB];
    assign setup_bits[g] = chain_w[g][sel];
  end

  // Next-state, buffer and pin-level decode.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    done_d     = 1'b0;

    if (start_i && (state_q != ST_IDLE)) begin
      pending_d  = data_i;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          shadow_d = data_i;
          bit_d    = LAST_BIT;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_tc) state_d = ST_CLOCK;
      end
      ST_CLOCK: begin
        if (phase_tc) begin
          if (bit_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            bit_d   = bit_q - CW'(1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_LATCH: begin
        if (phase_tc) begin
          done_d = 1'b1;
          // A request on the exit cycle is the newest one and supersedes any
          // older buffered frame.
          if (start_i) begin
            shadow_d   = data_i;
            pend_vld_d = 1'b0;
            bit_d      = LAST_BIT;
            state_d    = ST_SETUP;
          end else if (pend_vld_q) begin
            shadow_d   = pending_q;
            pend_vld_d = 1'b0;
            bit_d      = LAST_BIT;
            state_d    = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    sclk_d  = (state_d == ST_CLOCK);
    latch_d = (state_d == ST_LATCH);
    data_d  = data_q;
    if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) begin
      data_d = setup_bits;
    end
  end

  // Control state and pin registers; reset parks every pin low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      pend_vld_q <= pend_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      latch_q    <= latch_d;
      data_q     <= data_d;
    end
  end

  // Frame words; validity is tracked by state_q and pend_vld_q.
  always_ff @(posedge clk_i) begin
    shadow_q  <= shadow_d;
    pending_q <= pending_d;
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sclk_o  = sclk_q;
  assign latch_o = latch_q;
  assign data_o  = data_q;

endmodule
